mem_arbiter_ctrl: RTL and testbench
===================================

Name: mem_arbiter_ctrl

Overview:
- Sequencer and arbiter for the single byte-wide, synchronous-read RAM port shared by instruction fetch (IF) and the MEM stage.
- Accepts word fetches from IF and byte/half/word loads and stores from MEM. Grants one requester at a time and serialises the access into per-byte RAM cycles.
- Reads are assembled little-endian and returned with a one-cycle done pulse.
- Sits between the pipeline (pc_reg/if_id on the fetch side, mem on the data side) and the external RAM.

Parameters:
- ADDR_W, 17, width of the RAM byte address.
- DATA_W, 32, width of requester data words; fixed at 32.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_req_i  in  1  IF requests a 4-byte instruction read; level, held until if_done_o or cancel.
- if_addr_i  in  ADDR_W  IF byte address.
- if_cancel_i  in  1  abort the in-flight IF read (taken branch/flush).
- if_data_o  out  32  fetched instruction.
- if_done_o  out  1  one-cycle pulse; if_data_o is valid in that cycle.
- mem_req_i  in  1  MEM stage request; level, held until mem_done_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- mem_addr_i  in  ADDR_W  MEM byte address.
- mem_wdata_i  in  32  store data; low bytes used.
- mem_rdata_o  out  32  load data, zero-extended.
- mem_done_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high when state is not IDLE.
- ram_addr_o  out  ADDR_W  RAM byte address.
- ram_wr_o  out  1  RAM write strobe for the current cycle.
- ram_dout_o  out  8  RAM write byte.
- ram_din_i  in  8  RAM read byte; valid one cycle after its address was presented.

Behaviour:
- States: IDLE, RD, WR, DONE.
- Registers: base address, length N (1/2/4), issue index idx, owner (IF/MEM), 32-bit assembly buffer.
- Reset (any cycle, including mid-transfer): state IDLE, idx 0. All outputs 0: if_data_o, mem_rdata_o, done pulses, busy_o, ram_addr_o, ram_wr_o, ram_dout_o. No partial done is ever produced.
- Arbitration in IDLE only:
  - mem_req_i has fixed priority over if_req_i.
  - Request signals are sampled at the clock edge in IDLE and latched. Later changes to addr/data/size inputs are ignored until DONE.
- Grant transitions:
  - IDLE + grant for a load or fetch -> RD, idx 0.
  - IDLE + grant for a store -> WR, idx 0.
  - IDLE with no request: ram_wr_o 0, ram_addr_o holds its last value.
- RD state:
  - While idx < N: drive ram_addr_o = base+idx (mod 2^ADDR_W), ram_wr_o 0.
  - While idx >= 1: capture ram_din_i into byte idx-1 of the buffer.
  - Increment idx. When the capture of byte N-1 occurs (idx == N), go to DONE.
- WR state:
  - Drive ram_wr_o 1, ram_addr_o = base+idx, ram_dout_o = byte idx of the latched wdata.
  - After idx == N-1, go to DONE.
- DONE state, one cycle:
  - Pulse the owner's done signal.
  - For a read, present the buffer on if_data_o or mem_rdata_o. Byte/half reads are zero-extended.
  - Data outputs hold until the owner's next completion.
  - Go to IDLE. Requests are not sampled in DONE; requesters drop req on done.
- Latency from the edge that samples req in IDLE to the done pulse: word read 6 cycles, half read 4, byte read 3. Store of N bytes: N+1 cycles.
- if_cancel_i:
  - In RD with owner IF: go to IDLE next edge; no if_done_o; if_data_o unchanged. No RAM writes are affected.
  - Ignored when the owner is MEM or the state is IDLE.
  - If high in IDLE together with if_req_i, that IF request is not granted that cycle.
- Address wrap: base+idx is computed modulo 2^ADDR_W; no fault is raised.
- Simultaneous if_req and mem_req in IDLE: MEM is served first. IF is served in the IDLE cycle following MEM's DONE if still requested.
- busy_o is high in RD, WR and DONE.

Test Plan:
- Word fetch: IF reads 0x00010. RAM holds 0x13,0x05,0x10,0x00 at 0x10..0x13 -> ram_addr sequence 0x10..0x13. if_done_o pulses exactly 6 cycles after grant with if_data_o = 0x00100513.
- Store then load, byte: MEM stores mem_wdata 0xDEADBEEF, size 00, addr 0x00100 -> exactly one ram_wr_o cycle with addr 0x00100, dout 0xEF. A following byte load returns mem_rdata_o = 0x000000EF in 3 cycles.
- Half store: size 01 at 0x1FFFF -> writes at 0x1FFFF then 0x00000 (wrap), bytes 0xEF, 0xBE. mem_done_o arrives 3 cycles after grant.
- Contention: if_req and mem_req both rise in the same IDLE cycle -> MEM word load completes first. IF is granted in the IDLE after MEM DONE; no interleaved RAM addresses.
- Cancel: if_cancel_i asserted in the 3rd RD cycle of an IF fetch -> no if_done_o, state IDLE next cycle. A pending mem_req is granted in the following cycle.
- Reset mid-store: rst asserted during the 2nd WR cycle of a word store -> next cycle ram_wr_o 0, busy_o 0, no mem_done_o. Only 2 bytes were written.

Source files
------------

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates the shared byte-wide synchronous-read RAM between instruction fetch and the MEM stage.
// Each access is split into one RAM cycle per byte; read bytes are assembled little-endian.
module mem_arbiter_ctrl #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_cancel_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_done_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                own_mem_q, own_mem_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;

  logic [DATA_W-1:0]   if_data_d, mem_rdata_d;
  logic                if_done_d, mem_done_d, busy_d, ram_wr_d;
  logic [ADDR_W-1:0]   ram_addr_d;
  logic [7:0]          ram_dout_d;

  // Next-state logic; RAM outputs are computed from the next state so the
  // registered address/strobe lines up with the cycle that owns them.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    base_d      = base_q;
    own_mem_d   = own_mem_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    if_data_d   = if_data_o;
    mem_rdata_d = mem_rdata_o;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_addr_d  = ram_addr_o;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_o;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          own_mem_d = 1'b1;
          we_d      = mem_we_i;
          base_d    = mem_addr_i;
          wdata_d   = mem_wdata_i;
          rbuf_d    = '0;
          idx_d     = '0;
          case (mem_size_i)
            2'b00:   len_d = 3'd1;
            2'b01:   len_d = 3'd2;
            default: len_d = 3'd4;
          endcase
          state_d = mem_we_i ? WR : RD;
        end else if (if_req_i && !if_cancel_i) begin
          own_mem_d = 1'b0;
          we_d      = 1'b0;
          base_d    = if_addr_i;
          rbuf_d    = '0;
          idx_d     = '0;
          len_d     = 3'd4;
          state_d   = RD;
        end
      end
      RD: begin
        if (!own_mem_q && if_cancel_i) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          // RAM data lags its address by one cycle, so capture the previous byte.
          if (idx_q != 3'd0) rbuf_d[{2'(idx_q - 3'd1), 3'b000} +: 8] = ram_din_i;
          idx_d = idx_q + 3'd1;
          if (idx_q == len_q) state_d = DONE;
        end
      end
      WR: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == len_q - 3'd1) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
        if (own_mem_q) begin
          mem_done_d = 1'b1;
          if (!we_q) mem_rdata_d = rbuf_q;
        end else begin
          if_done_d = 1'b1;
          if_data_d = rbuf_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == WR) begin
      ram_wr_d   = 1'b1;
      ram_addr_d = base_d + ADDR_W'(idx_d);
      ram_dout_d = wdata_d[{idx_d[1:0], 3'b000} +: 8];
    end else if (state_d == RD && idx_d < len_d) begin
      ram_addr_d = base_d + ADDR_W'(idx_d);
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      own_mem_q   <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      if_data_o   <= '0;
      if_done_o   <= 1'b0;
      mem_rdata_o <= '0;
      mem_done_o  <= 1'b0;
      busy_o      <= 1'b0;
      ram_addr_o  <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      base_q      <= base_d;
      own_mem_q   <= own_mem_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      if_data_o   <= if_data_d;
      if_done_o   <= if_done_d;
      mem_rdata_o <= mem_rdata_d;
      mem_done_o  <= mem_done_d;
      busy_o      <= busy_d;
      ram_addr_o  <= ram_addr_d;
      ram_wr_o    <= ram_wr_d;
      ram_dout_o  <= ram_dout_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Scoreboard bench for mem_arbiter_ctrl with a byte-wide synchronous-read RAM model.
module tb_mem_arbiter_ctrl;

  localparam int unsigned ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_cancel = 1'b0;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [1:0]        mem_size = 2'b00;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [31:0]       mem_wdata = '0;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din = '0;

  mem_arbiter_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_cancel_i(if_cancel),
    .if_data_o(if_data), .if_done_o(if_done),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(mem_rdata), .mem_done_o(mem_done), .busy_o(busy),
    .ram_addr_o(ram_addr), .ram_wr_o(ram_wr), .ram_dout_o(ram_dout),
    .ram_din_i(ram_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [24:0] wlog[$];
  logic [16:0] alog[$];
  logic [7:0]  ram [0:(1<<ADDR_W)-1];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_mem_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: write on strobe, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_addr] <= ram_dout;
      wlog.push_back({ram_addr, ram_dout});
    end
    ram_din <= ram[ram_addr];
  end

  // Address trace of read traffic, consecutive duplicates removed.
  always @(negedge clk) begin
    if (busy && !ram_wr && (alog.size() == 0 || alog[$] != ram_addr))
      alog.push_back(ram_addr);
  end

  // Completion monitor: pop the oldest expectation on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (if_done || mem_done)) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("done_owner", 32'(mem_done), 32'(e.is_mem));
        if (e.is_mem) check("mem_rdata", mem_rdata, e.data);
        else          check("if_data", if_data, e.data);
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Run until both requesters have dropped and the scoreboard is drained.
  task automatic wait_idle(input int max);
    int n = 0;
    while ((if_req || mem_req || sb.size() != 0) && n < max) begin
      @(negedge clk);
      if (mem_done) mem_req = 1'b0;
      if (if_done)  if_req  = 1'b0;
      n++;
    end
    check("no_timeout", 32'(n >= max), 32'd0);
    @(negedge clk);
  endtask

  task automatic start_if(input logic [16:0] a, input logic [31:0] exp, input int lat);
    exp_t e;
    if_addr = a;
    if_req  = 1'b1;
    e.is_mem = 1'b0; e.data = exp; e.done_cyc = cyc + 1 + lat;
    sb.push_back(e);
  endtask

  task automatic start_mem(input bit we, input logic [1:0] sz, input logic [16:0] a,
                           input logic [31:0] wd, input logic [31:0] exp, input int lat);
    exp_t e;
    mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd;
    mem_req = 1'b1;
    if (!we) last_mem_rd = exp;
    e.is_mem = 1'b1; e.data = we ? last_mem_rd : exp; e.done_cyc = cyc + 1 + lat;
    sb.push_back(e);
  endtask

  int g;

  initial begin
    ram[17'h00010] = 8'h13; ram[17'h00011] = 8'h05;
    ram[17'h00012] = 8'h10; ram[17'h00013] = 8'h00;
    ram[17'h00200] = 8'h44; ram[17'h00201] = 8'h33;
    ram[17'h00202] = 8'h22; ram[17'h00203] = 8'h11;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_dout", 32'(ram_dout), 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word fetch
    alog.delete();
    start_if(17'h00010, 32'h00100513, 6);
    wait_idle(40);
    check("fetch_naddr", 32'(alog.size()), 32'd4);
    for (int i = 0; i < 4 && i < alog.size(); i++)
      check("fetch_addr", 32'(alog[i]), 32'h10 + 32'(i));

    // Byte store then byte load
    wlog.delete();
    start_mem(1'b1, 2'b00, 17'h00100, 32'hDEADBEEF, 32'h0, 2);
    wait_idle(40);
    check("bstore_nwr", 32'(wlog.size()), 32'd1);
    if (wlog.size() > 0) check("bstore_wr", 32'(wlog[0]), {7'd0, 17'h00100, 8'hEF});
    start_mem(1'b0, 2'b00, 17'h00100, 32'h0, 32'h000000EF, 3);
    wait_idle(40);

    // Half store wrapping past the top of the address space, then read it back
    wlog.delete();
    start_mem(1'b1, 2'b01, 17'h1FFFF, 32'hDEADBEEF, 32'h0, 3);
    wait_idle(40);
    check("hstore_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() > 1) begin
      check("hstore_wr0", 32'(wlog[0]), {7'd0, 17'h1FFFF, 8'hEF});
      check("hstore_wr1", 32'(wlog[1]), {7'd0, 17'h00000, 8'hBE});
    end
    start_mem(1'b0, 2'b01, 17'h1FFFF, 32'h0, 32'h0000BEEF, 4);
    wait_idle(40);

    // Contention: MEM first, IF in the idle cycle after MEM completes
    alog.delete();
    g = cyc + 1;
    start_mem(1'b0, 2'b10, 17'h00200, 32'h0, 32'h11223344, 6);
    start_if(17'h00010, 32'h00100513, 13);
    wait_idle(60);
    check("cont_naddr", 32'(alog.size()), 32'd8);
    for (int i = 0; i < 8 && i < alog.size(); i++)
      check("cont_addr", 32'(alog[i]), (i < 4) ? 32'h200 + 32'(i) : 32'h10 + 32'(i - 4));

    // Cancel in the third RD cycle with a MEM request arriving alongside
    if_addr = 17'h00200;
    if_req  = 1'b1;
    g = cyc + 1;
    wait_cyc(g + 2);
    if_cancel = 1'b1;
    if_req    = 1'b0;
    start_mem(1'b0, 2'b00, 17'h00100, 32'h0, 32'h000000EF, 4);
    @(negedge clk);
    if_cancel = 1'b0;
    check("cancel_idle", 32'(busy), 32'd0);
    wait_idle(40);
    check("cancel_if_data", if_data, 32'h00100513);

    // Reset during the second WR cycle of a word store
    wlog.delete();
    mem_we = 1'b1; mem_size = 2'b10; mem_addr = 17'h00300; mem_wdata = 32'hCAFEF00D;
    mem_req = 1'b1;
    g = cyc + 1;
    wait_cyc(g + 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    check("rstmid_ram_wr", 32'(ram_wr), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_mem_done", 32'(mem_done), 32'd0);
    check("rstmid_rdata", mem_rdata, 32'd0);
    check("rstmid_if_data", if_data, 32'd0);
    last_mem_rd = '0;
    repeat (8) @(negedge clk);
    check("rstmid_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() > 1) begin
      check("rstmid_wr0", 32'(wlog[0]), {7'd0, 17'h00300, 8'h0D});
      check("rstmid_wr1", 32'(wlog[1]), {7'd0, 17'h00301, 8'hF0});
    end

    // Normal operation after reset
    start_if(17'h00200, 32'h11223344, 6);
    wait_idle(40);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
